// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson phase decoder: phase count, legal code table, FSM encoding.
package johnson_pkg;

    localparam int NUM_PHASES = 8;
    localparam int PHASE_W    = 3;

    localparam logic [3:0] CODE_P0 = 4'b0000;
    localparam logic [3:0] CODE_P1 = 4'b1000;
    localparam logic [3:0] CODE_P2 = 4'b1100;
    localparam logic [3:0] CODE_P3 = 4'b1110;
    localparam logic [3:0] CODE_P4 = 4'b1111;
    localparam logic [3:0] CODE_P5 = 4'b0111;
    localparam logic [3:0] CODE_P6 = 4'b0011;
    localparam logic [3:0] CODE_P7 = 4'b0001;

    typedef enum logic {
        SEEK  = 1'b0,
        TRACK = 1'b1
    } state_e;

    typedef struct packed {
        logic               legal;
        logic [PHASE_W-1:0] phase;
    } lookup_t;

    function automatic logic [NUM_PHASES-1:0] phase_onehot(input logic [PHASE_W-1:0] p);
        return NUM_PHASES'(1) << p;
    endfunction

endpackage

// File: rtl/johnson_code_lookup.sv
// Combinational map from a 4-bit Johnson code to {legal, phase}; illegal codes return all zeros.
module johnson_code_lookup
    import johnson_pkg::*;
(
    input  logic [3:0] code_i,
    output lookup_t    result_o
);

    always_comb begin
        result_o = '0;
        case (code_i)
            CODE_P0: begin result_o.legal = 1'b1; result_o.phase = 3'd0; end
            CODE_P1: begin result_o.legal = 1'b1; result_o.phase = 3'd1; end
            CODE_P2: begin result_o.legal = 1'b1; result_o.phase = 3'd2; end
            CODE_P3: begin result_o.legal = 1'b1; result_o.phase = 3'd3; end
            CODE_P4: begin result_o.legal = 1'b1; result_o.phase = 3'd4; end
            CODE_P5: begin result_o.legal = 1'b1; result_o.phase = 3'd5; end
            CODE_P6: begin result_o.legal = 1'b1; result_o.phase = 3'd6; end
            CODE_P7: begin result_o.legal = 1'b1; result_o.phase = 3'd7; end
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Locks onto a Johnson counter sequence, reports phase, laps and errors.
// Optional saturating error counter on err_cnt when JPD_ERR_CNT_EN is defined.
module johnson_phase_decoder
    import johnson_pkg::*;
#(
    parameter int LAP_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            q_in,
    input  logic                  en,
    input  logic                  clr_err,
    output logic [PHASE_W-1:0]    phase,
    output logic [NUM_PHASES-1:0] phase_oh,
    output logic                  valid,
    output logic                  code_err,
    output logic                  step_err,
    output logic                  sticky_err,
    output logic [LAP_W-1:0]      lap_cnt
`ifdef JPD_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    lookup_t lk;

    johnson_code_lookup u_lookup (
        .code_i   (q_in),
        .result_o (lk)
    );

    state_e                  state_q, state_d;
    logic [PHASE_W-1:0]      phase_q, phase_d;
    logic [NUM_PHASES-1:0]   phase_oh_q, phase_oh_d;
    logic                    valid_q, valid_d;
    logic                    code_err_q, code_err_d;
    logic                    step_err_q, step_err_d;
    logic                    sticky_q, sticky_d;
    logic [LAP_W-1:0]        lap_q, lap_d;
    logic [PHASE_W-1:0]      succ;
    logic                    err_evt;

    assign succ    = phase_q + 1'b1;
    assign err_evt = code_err_d | step_err_d;

    // An illegal code always drops lock; legal codes either lock, hold, advance or resync.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        valid_d    = valid_q;
        code_err_d = 1'b0;
        step_err_d = 1'b0;
        lap_d      = lap_q;
        if (en) begin
            if (!lk.legal) begin
                code_err_d = 1'b1;
                valid_d    = 1'b0;
                state_d    = SEEK;
            end else if (state_q == SEEK) begin
                state_d = TRACK;
                phase_d = lk.phase;
                valid_d = 1'b1;
            end else if (lk.phase == succ) begin
                phase_d = succ;
                if (phase_q == PHASE_W'(NUM_PHASES - 1)) begin
                    lap_d = lap_q + LAP_W'(1);
                end
            end else if (lk.phase != phase_q) begin
                step_err_d = 1'b1;
                phase_d    = lk.phase;
            end
        end
        sticky_d   = err_evt ? 1'b1 : (clr_err ? 1'b0 : sticky_q);
        phase_oh_d = valid_d ? phase_onehot(phase_d) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SEEK;
            phase_q    <= '0;
            phase_oh_q <= '0;
            valid_q    <= 1'b0;
            code_err_q <= 1'b0;
            step_err_q <= 1'b0;
            sticky_q   <= 1'b0;
            lap_q      <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            phase_oh_q <= phase_oh_d;
            valid_q    <= valid_d;
            code_err_q <= code_err_d;
            step_err_q <= step_err_d;
            sticky_q   <= sticky_d;
            lap_q      <= lap_d;
        end
    end

    assign phase      = phase_q;
    assign phase_oh   = phase_oh_q;
    assign valid      = valid_q;
    assign code_err   = code_err_q;
    assign step_err   = step_err_q;
    assign sticky_err = sticky_q;
    assign lap_cnt    = lap_q;

`ifdef JPD_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // A new error beats a simultaneous clear, so the count restarts at one.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_evt) begin
            if (clr_err) begin
                err_cnt_d = 8'd1;
            end else if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end else if (clr_err) begin
            err_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Scoreboard bench for johnson_phase_decoder (LAP_W=2); checks err_cnt when JPD_ERR_CNT_EN is defined.
module tb_johnson_phase_decoder;

    logic       clk;
    logic       rst;
    logic [3:0] q_in;
    logic       en;
    logic       clr_err;
    logic [2:0] phase;
    logic [7:0] phase_oh;
    logic       valid;
    logic       code_err;
    logic       step_err;
    logic       sticky_err;
    logic [1:0] lap_cnt;
`ifdef JPD_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int numChecks = 0;
    int numFails  = 0;

    typedef struct {
        string      name;
        logic [2:0] ph;
        logic       v;
        logic [7:0] oh;
        logic       ce;
        logic       se;
        logic       st;
        logic [1:0] lap;
        logic [7:0] ec;
    } exp_t;

    exp_t sbq[$];

    johnson_phase_decoder #(.LAP_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .q_in       (q_in),
        .en         (en),
        .clr_err    (clr_err),
        .phase      (phase),
        .phase_oh   (phase_oh),
        .valid      (valid),
        .code_err   (code_err),
        .step_err   (step_err),
        .sticky_err (sticky_err),
        .lap_cnt    (lap_cnt)
`ifdef JPD_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] codeOf(input int p);
        case (p)
            0: return 4'b0000;
            1: return 4'b1000;
            2: return 4'b1100;
            3: return 4'b1110;
            4: return 4'b1111;
            5: return 4'b0111;
            6: return 4'b0011;
            default: return 4'b0001;
        endcase
    endfunction

    // Drive one vector at the falling edge and queue what the outputs must show after the next rising edge.
    task automatic applyStimulus(input string name, input logic [3:0] q, input logic e, input logic c,
                                 input logic [2:0] ph, input logic v, input logic ce, input logic se,
                                 input logic st, input logic [1:0] lap, input logic [7:0] ec);
        exp_t x;
        @(negedge clk);
        q_in    = q;
        en      = e;
        clr_err = c;
        x.name = name;
        x.ph   = ph;
        x.v    = v;
        x.oh   = v ? (8'b1 << ph) : 8'h00;
        x.ce   = ce;
        x.se   = se;
        x.st   = st;
        x.lap  = lap;
        x.ec   = ec;
        sbq.push_back(x);
    endtask

    task automatic checkOutput(input exp_t x);
        logic bad;
        numChecks++;
        bad = (phase !== x.ph) || (valid !== x.v) || (phase_oh !== x.oh) || (code_err !== x.ce) ||
              (step_err !== x.se) || (sticky_err !== x.st) || (lap_cnt !== x.lap);
`ifdef JPD_ERR_CNT_EN
        bad = bad || (err_cnt !== x.ec);
`endif
        if (bad) begin
            numFails++;
            $display("[TB] FAIL %s: got ph=%0d v=%b oh=%b ce=%b se=%b st=%b lap=%0d, want ph=%0d v=%b oh=%b ce=%b se=%b st=%b lap=%0d ec=%0d",
                     x.name, phase, valid, phase_oh, code_err, step_err, sticky_err, lap_cnt,
                     x.ph, x.v, x.oh, x.ce, x.se, x.st, x.lap, x.ec);
        end
    endtask

    task automatic checkReset(input string name);
        logic bad;
        numChecks++;
        bad = (phase !== 3'd0) || (valid !== 1'b0) || (phase_oh !== 8'h00) || (code_err !== 1'b0) ||
              (step_err !== 1'b0) || (sticky_err !== 1'b0) || (lap_cnt !== 2'd0);
`ifdef JPD_ERR_CNT_EN
        bad = bad || (err_cnt !== 8'd0);
`endif
        if (bad) begin
            numFails++;
            $display("[TB] FAIL %s: got ph=%0d v=%b oh=%b ce=%b se=%b st=%b lap=%0d, want all zero",
                     name, phase, valid, phase_oh, code_err, step_err, sticky_err, lap_cnt);
        end
    endtask

    task automatic drain();
        repeat (2) @(posedge clk);
        #2;
    endtask

    // Monitor: the outputs are presented every cycle, so pop one expectation per rising edge when one is pending.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                checkOutput(x);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] illCodes [5];
        int ec;
        illCodes[0] = 4'b1010;
        illCodes[1] = 4'b0101;
        illCodes[2] = 4'b0100;
        illCodes[3] = 4'b1001;
        illCodes[4] = 4'b1101;

        rst = 1'b0; en = 1'b0; q_in = 4'b0000; clr_err = 1'b0;
        #3;
        checkReset("reset_initial");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i <= 8; i++)
            applyStimulus("lap_seq", codeOf(i % 8), 1, 0, 3'(i % 8), 1, 0, 0, 0, (i == 8) ? 2'd1 : 2'd0, 8'd0);
        applyStimulus("hold0", 4'b0000, 1, 0, 3'd0, 1, 0, 0, 0, 2'd1, 8'd0);
        applyStimulus("hold0", 4'b0000, 1, 0, 3'd0, 1, 0, 0, 0, 2'd1, 8'd0);

        for (int l = 2; l <= 4; l++)
            for (int p = 1; p <= 8; p++)
                applyStimulus("lap_wrap", codeOf(p % 8), 1, 0, 3'(p % 8), 1, 0, 0, 0,
                              (p == 8) ? 2'(l % 4) : 2'(l - 1), 8'd0);

        applyStimulus("step_to_1", 4'b1000, 1, 0, 3'd1, 1, 0, 0, 0, 2'd0, 8'd0);
        applyStimulus("skip_err",  4'b1111, 1, 0, 3'd4, 1, 0, 1, 1, 2'd0, 8'd1);
        applyStimulus("skip_hold", 4'b1111, 1, 0, 3'd4, 1, 0, 0, 1, 2'd0, 8'd1);

        for (int i = 0; i < 5; i++)
            applyStimulus("en_low", illCodes[i], 0, 0, 3'd4, 1, 0, 0, 1, 2'd0, 8'd1);

        applyStimulus("clr_only",     4'b1111, 1, 1, 3'd4, 1, 0, 0, 0, 2'd0, 8'd0);
        applyStimulus("resync_2",     4'b1100, 1, 0, 3'd2, 1, 0, 1, 1, 2'd0, 8'd1);
        applyStimulus("clr_at_2",     4'b1100, 1, 1, 3'd2, 1, 0, 0, 0, 2'd0, 8'd0);
        applyStimulus("illegal_at_2", 4'b1010, 1, 0, 3'd2, 0, 1, 0, 1, 2'd0, 8'd1);
        applyStimulus("clr_vs_err",   4'b0110, 1, 1, 3'd2, 0, 1, 0, 1, 2'd0, 8'd1);
        applyStimulus("seek_relock",  4'b1110, 1, 0, 3'd3, 1, 0, 0, 1, 2'd0, 8'd1);

        for (int n = 1; n <= 256; n++) begin
            ec = (n + 1 > 255) ? 255 : n + 1;
            applyStimulus("err_sat", 4'b1010, 1, 0, 3'd3, 0, 1, 0, 1, 2'd0, 8'(ec));
        end
        applyStimulus("clr_relock", 4'b0000, 1, 1, 3'd0, 1, 0, 0, 0, 2'd0, 8'd0);

        for (int p = 1; p <= 8; p++)
            applyStimulus("lap_again", codeOf(p % 8), 1, 0, 3'(p % 8), 1, 0, 0, 0,
                          (p == 8) ? 2'd1 : 2'd0, 8'd0);
        applyStimulus("pre_reset", 4'b1000, 1, 0, 3'd1, 1, 0, 0, 0, 2'd1, 8'd0);
        applyStimulus("pre_reset", 4'b1100, 1, 0, 3'd2, 1, 0, 0, 0, 2'd1, 8'd0);
        drain();

        #2;
        rst = 1'b0;
        #1;
        checkReset("async_reset");
        @(negedge clk);
        rst = 1'b1;
        applyStimulus("post_reset", 4'b1110, 1, 0, 3'd3, 1, 0, 0, 0, 2'd0, 8'd0);
        drain();

        numChecks++;
        if (sbq.size() != 0) begin
            numFails++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
